// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter (mem_port_arbiter).
package mem_arb_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int PERF_CNT_W  = 16;
  localparam int IDX_W       = $clog2(MAX_MASTERS);

  typedef logic [IDX_W-1:0] master_idx_t;

  // Round-robin successor of idx among n masters.
  function automatic master_idx_t next_idx(input master_idx_t idx, input int n);
    if (int'(idx) == n - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Rotating-priority picker: first requester at or after rr_ptr, wrapping to 0.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  master_idx_t            rr_ptr,
  output logic                   valid,
  output master_idx_t            win
);

  int          sum;
  master_idx_t cand;

  always_comb begin
    valid = 1'b0;
    win   = '0;
    sum   = 0;
    cand  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      sum = int'(rr_ptr) + i;
      if (sum >= NUM_MASTERS) begin
        sum = sum - NUM_MASTERS;
      end
      cand = master_idx_t'(sum);
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (!valid && req[j] && (cand == master_idx_t'(j))) begin
          valid = 1'b1;
          win   = cand;
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one OBI-style memory port between NUM_MASTERS requesters.
// Optional perf counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_req_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]            m_gnt_o,
  output logic [NUM_MASTERS-1:0]            m_rvalid_o,
  output logic [DATA_WIDTH-1:0]             m_rdata_o,
  output logic                              mem_req_o,
  output logic                              mem_we_o,
  output logic [ADDR_WIDTH-1:0]             mem_addr_o,
  output logic [DATA_WIDTH-1:0]             mem_wdata_o,
  input  logic                              mem_gnt_i,
  input  logic                              mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]             mem_rdata_i
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [NUM_MASTERS*PERF_CNT_W-1:0] perf_gnt_cnt_o,
  output logic [PERF_CNT_W-1:0]             perf_conflict_o
`endif
);

  // Handshake: a request (req with we/addr/wdata) must be held until gnt is seen
  // high in the same cycle; the transfer is accepted on req & gnt at posedge, and
  // exactly one rvalid follows in the next cycle for every accepted transfer.

  logic        pick_valid;
  master_idx_t win;
  master_idx_t rr_ptr;
  master_idx_t owner_q;
  logic        pend_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic        accept;

  mem_arb_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_pick (
    .req    (m_req_i),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .win    (win)
  );

  always_comb begin
    mem_req_o   = pick_valid & ~rst;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    m_gnt_o     = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_valid && (win == master_idx_t'(i))) begin
        mem_we_o    = m_we_i[i];
        mem_addr_o  = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata_o = m_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        m_gnt_o[i]  = mem_gnt_i & ~rst;
      end
    end
  end

  assign accept = mem_req_o & mem_gnt_i;

  // Read data is captured in the grant cycle because the memory drives it
  // combinationally from the address that is only valid then.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      owner_q <= '0;
      pend_q  <= 1'b0;
      rdata_q <= '0;
    end else if (accept) begin
      rr_ptr  <= next_idx(win, NUM_MASTERS);
      owner_q <= win;
      pend_q  <= 1'b1;
      rdata_q <= mem_rdata_i;
    end else begin
      pend_q  <= 1'b0;
    end
  end

  // Gating with rst drops a response that was pending when reset arrived.
  always_comb begin
    m_rvalid_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_rvalid_o[i] = mem_rvalid_i & pend_q & ~rst & (owner_q == master_idx_t'(i));
    end
  end

  assign m_rdata_o = rdata_q;

`ifdef MEM_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] gnt_cnt_q [NUM_MASTERS];
  logic [PERF_CNT_W-1:0] conflict_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        gnt_cnt_q[i] <= '0;
      end
      conflict_q <= '0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (accept && (win == master_idx_t'(i)) && (gnt_cnt_q[i] != '1)) begin
          gnt_cnt_q[i] <= gnt_cnt_q[i] + 1'b1;
        end
      end
      if (($countones(m_req_i) >= 2) && (conflict_q != '1)) begin
        conflict_q <= conflict_q + 1'b1;
      end
    end
  end

  always_comb begin
    perf_gnt_cnt_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      perf_gnt_cnt_o[i*PERF_CNT_W +: PERF_CNT_W] = gnt_cnt_q[i];
    end
  end

  assign perf_conflict_o = conflict_q;
`endif

endmodule
